// File: rtl/dcache_ctrl_pkg.sv
// Shared types and helpers for the data-cache controller.
//   XLEN          : processor word width (32)
//   BUS_COMMAND   : main-memory bus command (NONE / LOAD / STORE)
//   MEM_SIZE      : bus access size (BYTE / HALF / WORD / DOUBLE)
//   DCACHE_STATE  : controller FSM state
//   DCACHE_LINE   : one cache line {valid, tag, data[63:0]}
// The line tag field is sized for the smallest possible index (XLEN-3 bits).
// Narrower tags are stored zero-extended, so one struct serves any NUM_LINES.
package dcache_ctrl_pkg;

    localparam int XLEN       = 32;
    localparam int LINE_TAG_W = XLEN - 3;

    typedef enum logic [1:0] {
        BUS_NONE  = 2'd0,
        BUS_LOAD  = 2'd1,
        BUS_STORE = 2'd2
    } BUS_COMMAND;

    typedef enum logic [1:0] {
        BYTE   = 2'd0,
        HALF   = 2'd1,
        WORD   = 2'd2,
        DOUBLE = 2'd3
    } MEM_SIZE;

    typedef enum logic [1:0] {
        DC_IDLE = 2'd0,
        DC_REQ  = 2'd1,
        DC_WAIT = 2'd2
    } DCACHE_STATE;

    typedef struct packed {
        logic                  valid;
        logic [LINE_TAG_W-1:0] tag;
        logic [63:0]           data;
    } DCACHE_LINE;

    // func3[1:0] selects the access width: 00 byte, 01 half, otherwise word.
    function automatic MEM_SIZE size_of(input logic [1:0] sz);
        MEM_SIZE s;
        case (sz)
            2'b00:   s = BYTE;
            2'b01:   s = HALF;
            default: s = WORD;
        endcase
        return s;
    endfunction

    // First byte of the access inside the 8-byte line; address bits below
    // the access size are dropped.
    function automatic logic [2:0] lane_base(input logic [2:0] off, input logic [1:0] sz);
        logic [2:0] b;
        case (sz)
            2'b00:   b = off;
            2'b01:   b = {off[2:1], 1'b0};
            default: b = {off[2], 2'b00};
        endcase
        return b;
    endfunction

    function automatic logic [7:0] byte_mask(input logic [2:0] base, input logic [1:0] sz);
        logic [7:0] m;
        case (sz)
            2'b00:   m = 8'h01 << base;
            2'b01:   m = 8'h03 << base;
            default: m = 8'h0F << base;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/dcache_ctrl_if.sv
// LSU-side request/response and main-memory bus signals of the data cache.
//   LSU   : mem_read, mem_write, mem_addr, func3, proc2Dmem_data -> mem_hit, load_data
//   Bus   : proc2mem_command/addr/data/size -> mem2proc_response, mem2proc_data, mem2proc_tag
// Handshake: the LSU holds mem_read or mem_write (with address, func3 and data
// stable) until it sees mem_hit high; the request completes in that cycle.
// On the bus a request is accepted in the cycle mem2proc_response is nonzero,
// and that value is the transaction tag; data for it returns later in a cycle
// where mem2proc_tag equals that tag (mem2proc_tag 0 means no data).
// Modport slave is the cache; modport master is the LSU + memory environment.
interface dcache_ctrl_if;
    import dcache_ctrl_pkg::*;

    logic                 mem_read;
    logic                 mem_write;
    logic [XLEN-1:0]      mem_addr;
    logic [2:0]           func3;
    logic [XLEN-1:0]      proc2Dmem_data;
    logic                 mem_hit;
    logic [XLEN-1:0]      load_data;
    BUS_COMMAND           proc2mem_command;
    logic [XLEN-1:0]      proc2mem_addr;
    logic [63:0]          proc2mem_data;
    MEM_SIZE              proc2mem_size;
    logic [3:0]           mem2proc_response;
    logic [63:0]          mem2proc_data;
    logic [3:0]           mem2proc_tag;

    modport slave (
        input  mem_read, mem_write, mem_addr, func3, proc2Dmem_data,
        input  mem2proc_response, mem2proc_data, mem2proc_tag,
        output mem_hit, load_data,
        output proc2mem_command, proc2mem_addr, proc2mem_data, proc2mem_size
    );

    modport master (
        output mem_read, mem_write, mem_addr, func3, proc2Dmem_data,
        output mem2proc_response, mem2proc_data, mem2proc_tag,
        input  mem_hit, load_data,
        input  proc2mem_command, proc2mem_addr, proc2mem_data, proc2mem_size
    );

endinterface

// File: rtl/dcache_mem.sv
// Direct-mapped line storage for the data cache.
//   clk, reset  : clock, synchronous active-high reset (clears valid bits only)
//   rd_idx_i    : combinational read index
//   rd_line_o   : line at rd_idx_i
//   wr_en_i     : write strobe; sets the line valid and rewrites its tag
//   wr_idx_i    : write index
//   wr_tag_i    : tag written with the line
//   wr_data_i   : 64-bit write data, bytes already in their lanes
//   wr_be_i     : byte enables (all ones for a fill, store mask for a merge)
module dcache_mem
    import dcache_ctrl_pkg::*;
#(
    parameter int NUM_LINES = 32,
    localparam int IDX_W    = $clog2(NUM_LINES)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [IDX_W-1:0]      rd_idx_i,
    output DCACHE_LINE            rd_line_o,
    input  logic                  wr_en_i,
    input  logic [IDX_W-1:0]      wr_idx_i,
    input  logic [LINE_TAG_W-1:0] wr_tag_i,
    input  logic [63:0]           wr_data_i,
    input  logic [7:0]            wr_be_i
);

    logic [NUM_LINES-1:0]  valid_q;
    logic [LINE_TAG_W-1:0] tag_q  [NUM_LINES];
    logic [63:0]           data_q [NUM_LINES];

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= '0;
        end else if (wr_en_i) begin
            valid_q[wr_idx_i] <= 1'b1;
        end
    end

    // Tag and data need no reset: they are only looked at behind a valid bit.
    always_ff @(posedge clk) begin
        if (!reset && wr_en_i) begin
            tag_q[wr_idx_i] <= wr_tag_i;
            for (int b = 0; b < 8; b++) begin
                if (wr_be_i[b]) begin
                    data_q[wr_idx_i][8*b +: 8] <= wr_data_i[8*b +: 8];
                end
            end
        end
    end

    assign rd_line_o.valid = valid_q[rd_idx_i];
    assign rd_line_o.tag   = tag_q[rd_idx_i];
    assign rd_line_o.data  = data_q[rd_idx_i];

endmodule

// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-through, no-write-allocate data cache with one
// outstanding load miss, between the LSU and the 64-bit tagged memory bus.
//   clk, reset  : clock, synchronous active-high reset
//   bus         : dcache_ctrl_if.slave (LSU request/response + memory bus)
//   dbg_state_o : current controller state
// Load hits answer in the request cycle. A load miss issues BUS_LOAD (retried
// from REQ while the bus rejects it), waits in WAIT for its tag, installs the
// line and returns to IDLE, where the still-held LSU request then hits.
// Stores always go to the bus; mem_hit follows bus acceptance and a resident
// line is merged on that same edge.
module dcache_ctrl
    import dcache_ctrl_pkg::*;
#(
    parameter int NUM_LINES = 32
) (
    input  logic          clk,
    input  logic          reset,
    dcache_ctrl_if.slave  bus,
    output DCACHE_STATE   dbg_state_o
);

    localparam int IDX_W = $clog2(NUM_LINES);
    localparam int TAG_W = XLEN - 3 - IDX_W;

    DCACHE_STATE       state_q, state_d;
    logic [XLEN-4:0]   miss_line_q, miss_line_d;   // line address of the miss
    logic [3:0]        bus_tag_q, bus_tag_d;       // 0 = nothing outstanding

    // Request decode; a read wins if both strobes are high.
    logic                  req_rd, req_wr;
    logic [2:0]            req_off;
    logic [IDX_W-1:0]      req_idx;
    logic [LINE_TAG_W-1:0] req_tag;
    logic [2:0]            acc_base;

    assign req_rd   = bus.mem_read;
    assign req_wr   = bus.mem_write & ~bus.mem_read;
    assign req_off  = bus.mem_addr[2:0];
    assign req_idx  = bus.mem_addr[3 +: IDX_W];
    assign req_tag  = LINE_TAG_W'(bus.mem_addr[XLEN-1 -: TAG_W]);
    assign acc_base = lane_base(req_off, bus.func3[1:0]);

    // Line array
    DCACHE_LINE            rd_line;
    logic                  wr_en;
    logic [IDX_W-1:0]      wr_idx;
    logic [LINE_TAG_W-1:0] wr_tag;
    logic [63:0]           wr_data;
    logic [7:0]            wr_be;

    dcache_mem #(.NUM_LINES(NUM_LINES)) u_mem (
        .clk       (clk),
        .reset     (reset),
        .rd_idx_i  (req_idx),
        .rd_line_o (rd_line),
        .wr_en_i   (wr_en),
        .wr_idx_i  (wr_idx),
        .wr_tag_i  (wr_tag),
        .wr_data_i (wr_data),
        .wr_be_i   (wr_be)
    );

    logic hit, bus_accept, fill;
    assign hit        = rd_line.valid && (rd_line.tag == req_tag);
    assign bus_accept = (bus.mem2proc_response != 4'd0);
    // bus_tag_q is nonzero whenever WAIT is entered; the explicit check keeps
    // a zero (no data) tag from ever completing a fill.
    assign fill       = (state_q == DC_WAIT) && (bus_tag_q != 4'd0) &&
                        (bus.mem2proc_tag == bus_tag_q);

    // Load extraction and extension; func3[2] set means zero-extend.
    logic [XLEN-1:0] ld_word, load_ext;
    logic            sx;
    assign ld_word = XLEN'(rd_line.data >> {acc_base, 3'b000});
    assign sx      = ~bus.func3[2];

    always_comb begin
        case (bus.func3[1:0])
            2'b00:   load_ext = {{(XLEN-8){sx & ld_word[7]}},   ld_word[7:0]};
            2'b01:   load_ext = {{(XLEN-16){sx & ld_word[15]}}, ld_word[15:0]};
            default: load_ext = ld_word;
        endcase
    end

    // Store data moved into its byte lane(s) of the 64-bit bus word.
    logic [63:0] st_raw, store_lane;
    always_comb begin
        case (bus.func3[1:0])
            2'b00:   st_raw = {56'd0, bus.proc2Dmem_data[7:0]};
            2'b01:   st_raw = {48'd0, bus.proc2Dmem_data[15:0]};
            default: st_raw = {{(64-XLEN){1'b0}}, bus.proc2Dmem_data};
        endcase
    end
    assign store_lane = st_raw << {acc_base, 3'b000};

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= DC_IDLE;
            miss_line_q <= '0;
            bus_tag_q   <= 4'd0;
        end else begin
            state_q     <= state_d;
            miss_line_q <= miss_line_d;
            bus_tag_q   <= bus_tag_d;
        end
    end

    // Next state
    always_comb begin
        state_d     = state_q;
        miss_line_d = miss_line_q;
        bus_tag_d   = bus_tag_q;
        case (state_q)
            DC_IDLE: begin
                if (req_rd && !hit) begin
                    miss_line_d = bus.mem_addr[XLEN-1:3];
                    if (bus_accept) begin
                        bus_tag_d = bus.mem2proc_response;
                        state_d   = DC_WAIT;
                    end else begin
                        state_d   = DC_REQ;
                    end
                end
            end
            DC_REQ: begin
                if (bus_accept) begin
                    bus_tag_d = bus.mem2proc_response;
                    state_d   = DC_WAIT;
                end
            end
            DC_WAIT: begin
                // Installed regardless of whether the LSU still wants it.
                if (fill) begin
                    bus_tag_d = 4'd0;
                    state_d   = DC_IDLE;
                end
            end
            default: state_d = DC_IDLE;
        endcase
    end

    // Outputs and line-array write port
    logic            hit_o;
    logic [XLEN-1:0] load_o;
    BUS_COMMAND      cmd_o;
    logic [XLEN-1:0] addr_o;
    logic [63:0]     data_o;
    MEM_SIZE         size_o;

    always_comb begin
        hit_o   = 1'b0;
        load_o  = '0;
        cmd_o   = BUS_NONE;
        addr_o  = '0;
        data_o  = '0;
        size_o  = BYTE;
        wr_en   = 1'b0;
        wr_idx  = req_idx;
        wr_tag  = req_tag;
        wr_data = store_lane;
        wr_be   = byte_mask(acc_base, bus.func3[1:0]);
        if (!reset) begin
            case (state_q)
                DC_IDLE: begin
                    if (req_rd) begin
                        if (hit) begin
                            hit_o  = 1'b1;
                            load_o = load_ext;
                        end else begin
                            cmd_o  = BUS_LOAD;
                            addr_o = {bus.mem_addr[XLEN-1:3], 3'b000};
                            size_o = DOUBLE;
                        end
                    end else if (req_wr) begin
                        cmd_o  = BUS_STORE;
                        addr_o = bus.mem_addr;
                        data_o = store_lane;
                        size_o = size_of(bus.func3[1:0]);
                        hit_o  = bus_accept;
                        wr_en  = bus_accept && hit;
                    end
                end
                DC_REQ: begin
                    cmd_o  = BUS_LOAD;
                    addr_o = {miss_line_q, 3'b000};
                    size_o = DOUBLE;
                end
                DC_WAIT: begin
                    if (fill) begin
                        wr_en   = 1'b1;
                        wr_idx  = miss_line_q[IDX_W-1:0];
                        wr_tag  = LINE_TAG_W'(miss_line_q[XLEN-4 -: TAG_W]);
                        wr_data = bus.mem2proc_data;
                        wr_be   = 8'hFF;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.mem_hit          = hit_o;
    assign bus.load_data        = load_o;
    assign bus.proc2mem_command = cmd_o;
    assign bus.proc2mem_addr    = addr_o;
    assign bus.proc2mem_data    = data_o;
    assign bus.proc2mem_size    = size_o;
    assign dbg_state_o          = state_q;

endmodule
